// File: rtl/board_io_regs.sv
// Memory-mapped board I/O block: LEDs, PWM RGB LEDs, debounced switches and
// buttons with latched edge events, free-running counter and a level IRQ.
module board_io_regs #(
  parameter int N_LED      = 4,
  parameter int N_RGB      = 2,
  parameter int N_SW       = 4,
  parameter int N_BTN      = 4,
  parameter int PWM_BITS   = 8,
  parameter int DEB_CYCLES = 48000
) (
  input  logic                 I_clk,
  input  logic                 I_rst,
  input  logic                 I_mem_select,
  input  logic [5:0]           I_mem_address,
  input  logic [3:0]           I_mem_byte_we,
  input  logic [31:0]          I_mem_data_write,
  output logic [31:0]          O_mem_data_read,
  output logic                 O_mem_pause,
  input  logic [N_SW-1:0]      I_sw,
  input  logic [N_BTN-1:0]     I_btn,
  output logic [N_LED-1:0]     O_led,
  output logic [3*N_RGB-1:0]   O_rgb,
  output logic                 O_irq
);

  localparam int N_IN = N_SW + N_BTN;
  localparam int N_CH = 3 * N_RGB;
  localparam int CW   = $clog2(DEB_CYCLES);

  localparam logic [5:0] A_LED     = 6'd0;
  localparam logic [5:0] A_CTRL    = 6'd1;
  localparam logic [5:0] A_INPUT   = 6'd2;
  localparam logic [5:0] A_EVENT   = 6'd3;
  localparam logic [5:0] A_IRQ_EN  = 6'd4;
  localparam logic [5:0] A_COUNTER = 6'd5;

  logic                w_wr;
  logic                w_rd;
  logic [N_LED-1:0]    r_led_out;
  logic [1:0]          r_ctrl;
  logic [15:0]         r_event;
  logic [15:0]         r_irq_en;
  logic [31:0]         r_counter;
  logic                r_irq;
  logic [31:0]         r_rdata;
  logic [31:0]         w_rd_word;
  logic [N_IN-1:0]     w_raw;
  logic [N_IN-1:0]     r_sync1;
  logic [N_IN-1:0]     r_sync2;
  logic [N_IN-1:0]     w_stable;
  logic [N_IN-1:0]     r_input;
  logic [N_BTN-1:0]    w_btn_stable;
  logic [N_BTN-1:0]    w_btn_input;
  logic [15:0]         w_ev_set;
  logic [15:0]         w_ev_clr;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] w_duty [N_CH];
  logic                w_unused_ok;

  assign w_wr        = I_mem_select && (I_mem_byte_we != 4'b0000);
  assign w_rd        = I_mem_select && (I_mem_byte_we == 4'b0000);
  assign w_unused_ok = ^I_mem_data_write;

  // Plain registers, counter and interrupt
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_led_out <= '0;
      r_ctrl    <= '0;
      r_irq_en  <= '0;
      r_counter <= '0;
      r_event   <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_counter <= r_counter + 32'd1;
      r_event   <= (r_event & ~w_ev_clr) | w_ev_set;
      r_irq     <= |(r_event & r_irq_en);
      if (w_wr && I_mem_address == A_LED && I_mem_byte_we[0])
        r_led_out <= I_mem_data_write[N_LED-1:0];
      if (w_wr && I_mem_address == A_CTRL && I_mem_byte_we[0])
        r_ctrl <= I_mem_data_write[1:0];
      if (w_wr && I_mem_address == A_IRQ_EN) begin
        if (I_mem_byte_we[0]) r_irq_en[7:0]  <= I_mem_data_write[7:0];
        if (I_mem_byte_we[1]) r_irq_en[15:8] <= I_mem_data_write[15:8];
      end
    end
  end

  assign O_led       = r_ctrl[0] ? r_counter[31 -: N_LED] : r_led_out;
  assign O_irq       = r_irq;
  assign O_mem_pause = 1'b0;

  // Synchronisers; r_input is the architecturally visible debounced state
  assign w_raw = {I_btn, I_sw};

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_input <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_input <= w_stable;
    end
  end

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
      logic [CW-1:0] r_cnt;
      logic          r_stable;

      always_ff @(posedge I_clk) begin
        if (I_rst) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_sync2[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_stable <= ~r_stable;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  // Button edges are taken between the debounced state and its delayed copy
  assign w_btn_stable = w_stable[N_IN-1:N_SW];
  assign w_btn_input  = r_input[N_IN-1:N_SW];

  always_comb begin
    w_ev_set = '0;
    w_ev_set[N_BTN-1:0]   = w_btn_stable & ~w_btn_input;
    w_ev_set[8 +: N_BTN]  = ~w_btn_stable & w_btn_input;
    w_ev_clr = '0;
    if (w_wr && I_mem_address == A_EVENT) begin
      if (I_mem_byte_we[0]) w_ev_clr[7:0]  = I_mem_data_write[7:0];
      if (I_mem_byte_we[1]) w_ev_clr[15:8] = I_mem_data_write[15:8];
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) r_pwm_cnt <= '0;
    else       r_pwm_cnt <= r_pwm_cnt + 1'b1;
  end

  // Channel gi drives colour gi%3 (r,g,b) of RGB LED gi/3
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_pwm
      localparam int K   = gi / 3;
      localparam int COL = gi % 3;
      logic [PWM_BITS-1:0] r_duty;
      logic [PWM_BITS-1:0] r_duty_act;
      logic                r_out;

      always_ff @(posedge I_clk) begin
        if (I_rst) begin
          r_duty     <= '0;
          r_duty_act <= '0;
          r_out      <= 1'b0;
        end else begin
          if (w_wr && int'(I_mem_address) == 8 + K && I_mem_byte_we[COL])
            r_duty <= I_mem_data_write[8*COL +: PWM_BITS];
          if (r_pwm_cnt == '1)
            r_duty_act <= r_duty;
          r_out <= r_ctrl[1] && (r_pwm_cnt < r_duty_act);
        end
      end

      assign w_duty[gi] = r_duty;
      assign O_rgb[gi]  = r_out;
    end
  endgenerate

  always_comb begin
    w_rd_word = '0;
    case (I_mem_address)
      A_LED:     w_rd_word[N_LED-1:0] = r_led_out;
      A_CTRL:    w_rd_word[1:0] = r_ctrl;
      A_INPUT: begin
        w_rd_word[N_SW-1:0]  = r_input[N_SW-1:0];
        w_rd_word[8 +: N_BTN] = w_btn_input;
      end
      A_EVENT:   w_rd_word[15:0] = r_event;
      A_IRQ_EN:  w_rd_word[15:0] = r_irq_en;
      A_COUNTER: w_rd_word = r_counter;
      default: begin
        for (int k = 0; k < N_RGB; k++) begin
          if (int'(I_mem_address) == 8 + k) begin
            for (int c = 0; c < 3; c++)
              w_rd_word[8*c +: PWM_BITS] = w_duty[3*k + c];
          end
        end
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst)     r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rd_word;
  end

  assign O_mem_data_read = r_rdata;

endmodule
